// File: rtl/unidad_fetch.sv
// unidad_fetch: instruction fetch stage in front of a byte-wide ROM.
// Owns the PC, latches the four ROM bytes into an instruction register,
// and handles decode back-pressure, branch redirect/flush and halt-on-opcode.
module unidad_fetch #(
    parameter int              PC_W        = 8,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter logic [7:0]      HALT_OPCODE = 8'hFF
) (
    input  logic            clk,
    input  logic            reset,
    output logic [PC_W-1:0] direccion,
    input  logic [7:0]      b1,
    input  logic [7:0]      b2,
    input  logic [7:0]      b3,
    input  logic [7:0]      b4,
    input  logic            salto_valido,
    input  logic [PC_W-1:0] salto_dest,
    input  logic            dec_listo,
    output logic [31:0]     instr_out,
    output logic [PC_W-1:0] instr_pc,
    output logic            instr_valida,
    output logic            halted
);

    typedef enum logic {FETCH = 1'b0, HALT = 1'b1} estado_t;

    // Instruction register handed to decode.
    typedef struct packed {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
        logic            valida;
    } ir_t;

    estado_t         estado_q, estado_d;
    logic [PC_W-1:0] pc_q, pc_d;
    ir_t             ir_q, ir_d;
    logic            halt_q, halt_d;
    logic            slot_libre;

    // The slot frees up either when empty or when decode takes it this edge,
    // so capture and acceptance can share an edge with no bubble.
    assign slot_libre = !ir_q.valida || dec_listo;

    // Next-state / next-register logic; redirect outranks everything but reset.
    always_comb begin
        estado_d = estado_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        halt_d   = halt_q;
        if (salto_valido) begin
            // Flush unconditionally: the held instruction is on the wrong path.
            pc_d      = salto_dest;
            ir_d.valida = 1'b0;
            halt_d    = 1'b0;
            estado_d  = FETCH;
        end else begin
            case (estado_q)
                FETCH: begin
                    if (slot_libre) begin
                        ir_d.instr  = {b1, b2, b3, b4};
                        ir_d.pc     = pc_q;
                        ir_d.valida = 1'b1;
                        if (b1 == HALT_OPCODE) begin
                            // Keep the PC on the halt word so a later redirect is the only exit.
                            estado_d = HALT;
                            halt_d   = 1'b1;
                        end else begin
                            pc_d = pc_q + PC_W'(4);
                        end
                    end
                end
                HALT: begin
                    if (dec_listo && ir_q.valida)
                        ir_d.valida = 1'b0;
                end
                default: estado_d = FETCH;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            halt_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            halt_q   <= halt_d;
        end
    end

    assign direccion    = pc_q;
    assign instr_out    = ir_q.instr;
    assign instr_pc     = ir_q.pc;
    assign instr_valida = ir_q.valida;
    assign halted       = halt_q;

endmodule

// File: tb/tb_unidad_fetch.sv
// Directed bench for unidad_fetch: a ROM model feeds the bytes, a scoreboard
// holds the instructions decode should accept, directed checks cover PC/flags.
module tb_unidad_fetch;

    logic        clk;
    logic        reset;
    logic [7:0]  direccion;
    logic [7:0]  b1, b2, b3, b4;
    logic        salto_valido;
    logic [7:0]  salto_dest;
    logic        dec_listo;
    logic [31:0] instr_out;
    logic [7:0]  instr_pc;
    logic        instr_valida;
    logic        halted;

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] word;
    } exp_t;

    logic [7:0] rom [256];
    exp_t       exp_q [$];
    exp_t       e;
    int         n_checks = 0;
    int         n_err    = 0;

    unidad_fetch #(.PC_W(8), .RESET_PC(8'h00), .HALT_OPCODE(8'hFF)) dut (
        .clk          (clk),
        .reset        (reset),
        .direccion    (direccion),
        .b1           (b1),
        .b2           (b2),
        .b3           (b3),
        .b4           (b4),
        .salto_valido (salto_valido),
        .salto_dest   (salto_dest),
        .dec_listo    (dec_listo),
        .instr_out    (instr_out),
        .instr_pc     (instr_pc),
        .instr_valida (instr_valida),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ROM, byte addresses wrap at 256.
    assign b1 = rom[direccion];
    assign b2 = rom[8'(direccion + 8'd1)];
    assign b3 = rom[8'(direccion + 8'd2)];
    assign b4 = rom[8'(direccion + 8'd3)];

    function automatic logic [31:0] word_at(input logic [7:0] pc);
        return {rom[pc], rom[8'(pc + 8'd1)], rom[8'(pc + 8'd2)], rom[8'(pc + 8'd3)]};
    endfunction

    task automatic push(input logic [7:0] pc);
        exp_t x;
        x.pc   = pc;
        x.word = word_at(pc);
        exp_q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Scoreboard: an instruction is consumed on the edge where decode is ready
    // and neither reset nor a redirect discards it.
    always @(negedge clk) begin
        if (!reset && !salto_valido && instr_valida && dec_listo) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_err++;
                $error("FAIL sb_unexpected: got pc=%h instr=%h expected none", instr_pc, instr_out);
            end else begin
                e = exp_q.pop_front();
                assert (instr_pc === e.pc && instr_out === e.word) else begin
                    n_err++;
                    $error("FAIL sb_accept: got pc=%h instr=%h expected pc=%h instr=%h",
                           instr_pc, instr_out, e.pc, e.word);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'h5A;
        reset = 1'b1; salto_valido = 1'b0; salto_dest = 8'h00; dec_listo = 1'b0;
        tick(); tick();
        chk("rst_valida", 32'(instr_valida), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_instr",  instr_out, 32'd0);
        chk("rst_ipc",    32'(instr_pc), 32'h00);
        chk("rst_dir",    32'(direccion), 32'h00);

        // T1: full throughput from reset.
        reset = 1'b0; dec_listo = 1'b1;
        push(8'h00); push(8'h04); push(8'h08);
        tick(); chk("t1_ipc0", 32'(instr_pc), 32'h00); chk("t1_val", 32'(instr_valida), 32'd1);
        tick(); chk("t1_ipc4", 32'(instr_pc), 32'h04);
        tick(); chk("t1_ipc8", 32'(instr_pc), 32'h08); chk("t1_dir", 32'(direccion), 32'h0C);

        // T2: three stall clocks hold everything.
        dec_listo = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t2_dir",   32'(direccion), 32'h0C);
            chk("t2_ipc",   32'(instr_pc), 32'h08);
            chk("t2_instr", instr_out, word_at(8'h08));
            chk("t2_val",   32'(instr_valida), 32'd1);
        end
        dec_listo = 1'b1; push(8'h0C);
        tick(); chk("t2_resume", 32'(instr_pc), 32'h0C);
        tick(); chk("t2_ipc10", 32'(instr_pc), 32'h10);  // will be flushed, not pushed

        // T3: redirect to 40 while decode is stalled.
        salto_valido = 1'b1; salto_dest = 8'h40; dec_listo = 1'b0;
        tick(); chk("t3_bubble", 32'(instr_valida), 32'd0); chk("t3_dir", 32'(direccion), 32'h40);
        salto_valido = 1'b0; push(8'h40);
        tick(); chk("t3_ipc", 32'(instr_pc), 32'h40); chk("t3_val", 32'(instr_valida), 32'd1);
        chk("t3_dir2", 32'(direccion), 32'h44);

        // T4: redirect with decode ready still flushes, then wrap FC -> 00.
        dec_listo = 1'b1;
        tick(); chk("t4_ipc44", 32'(instr_pc), 32'h44);
        salto_valido = 1'b1; salto_dest = 8'hFC;
        tick(); chk("t4_flush", 32'(instr_valida), 32'd0); chk("t4_dir", 32'(direccion), 32'hFC);
        salto_valido = 1'b0; push(8'hFC); push(8'h00);
        tick(); chk("t4_ipcFC", 32'(instr_pc), 32'hFC); chk("t4_wrap", 32'(direccion), 32'h00);
        tick(); chk("t4_ipc00", 32'(instr_pc), 32'h00);

        // T5: halt opcode at 0x10.
        rom[8'h10] = 8'hFF;
        push(8'h04); push(8'h08); push(8'h0C); push(8'h10);
        tick(); tick(); tick();
        chk("t5_ipc0C", 32'(instr_pc), 32'h0C); chk("t5_nohalt", 32'(halted), 32'd0);
        tick();
        chk("t5_ipc10", 32'(instr_pc), 32'h10); chk("t5_halted", 32'(halted), 32'd1);
        chk("t5_val", 32'(instr_valida), 32'd1); chk("t5_dir", 32'(direccion), 32'h10);
        tick();
        chk("t5_drain", 32'(instr_valida), 32'd0); chk("t5_hold", 32'(direccion), 32'h10);
        tick();
        chk("t5_stay", 32'(halted), 32'd1); chk("t5_val2", 32'(instr_valida), 32'd0);
        salto_valido = 1'b1; salto_dest = 8'h20;
        tick(); chk("t5_unhalt", 32'(halted), 32'd0); chk("t5_dir20", 32'(direccion), 32'h20);
        salto_valido = 1'b0; dec_listo = 1'b0;
        tick(); chk("t5_ipc20", 32'(instr_pc), 32'h20); chk("t5_val20", 32'(instr_valida), 32'd1);
        rom[8'h10] = 8'h10 ^ 8'h5A;

        // T6: reset during a stall with a valid instruction held.
        tick(); chk("t6_stall", 32'(instr_pc), 32'h20); chk("t6_dir", 32'(direccion), 32'h24);
        reset = 1'b1;
        tick();
        chk("t6_val", 32'(instr_valida), 32'd0); chk("t6_ipc", 32'(instr_pc), 32'h00);
        chk("t6_instr", instr_out, 32'd0); chk("t6_halt", 32'(halted), 32'd0);
        chk("t6_dir0", 32'(direccion), 32'h00);
        reset = 1'b0; dec_listo = 1'b1; push(8'h00); push(8'h04);
        tick(); chk("t6_ipc00", 32'(instr_pc), 32'h00);
        tick(); chk("t6_ipc04", 32'(instr_pc), 32'h04);
        tick(); dec_listo = 1'b0;
        tick(); tick();

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
